// File: rtl/pid_pkg.sv
// Shared widths, FSM state type and saturation helper for the heading PID datapath.
package pid_pkg;

  localparam int ERR_W   = 11;
  localparam int INTEG_W = 16;
  localparam int I_W     = 12;
  localparam int D_W     = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } pid_state_e;

  // Clamp a signed value into the range of a 'width'-bit two's-complement number.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                    input int unsigned width);
    logic signed [31:0] max_v;
    logic signed [31:0] min_v;
    max_v = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
    min_v = -max_v - 32'sd1;
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end else begin
      return val;
    end
  endfunction

endpackage

// File: rtl/id_terms_if.sv
// Sample-in / terms-out bundle between the proportional stage, id_terms and the PID summer.
interface id_terms_if;
  import pid_pkg::*;

  logic                    moving;
  logic                    hdng_vld;
  logic signed [ERR_W-1:0] err_sat;
  logic signed [I_W-1:0]   I_term;
  logic signed [D_W-1:0]   D_term;
  logic                    terms_vld;

  modport master (output moving, hdng_vld, err_sat, input I_term, D_term, terms_vld);
  modport slave  (input moving, hdng_vld, err_sat, output I_term, D_term, terms_vld);
endinterface

// File: rtl/id_terms_err_hist.sv
// Heading-error history: DEPTH-deep shift register, newest at index 0, with fill tracking.
module err_hist
  import pid_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ERR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                shift_i,
  input  logic signed [W-1:0] din_i,
  output logic signed [W-1:0] oldest_o,
  output logic                full_o,
  output logic                last_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic signed [W-1:0] hist_q [DEPTH];
  logic signed [W-1:0] hist_d [DEPTH];
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) hist_d[k] = '0;
      cnt_d = '0;
    end else if (shift_i) begin
      hist_d[0] = din_i;
      for (int k = 1; k < DEPTH; k++) hist_d[k] = hist_q[k-1];
      // Count saturates at DEPTH so full stays asserted while samples keep arriving.
      if (cnt_q != CNT_W'(DEPTH)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  assign oldest_o = hist_q[DEPTH-1];
  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign last_o   = (cnt_q == CNT_W'(DEPTH - 1));

endmodule

// File: rtl/id_terms.sv
// Integral and derivative term generator for the heading PID loop.
// Define ID_TERM_ANTIWINDUP_EN to hold the integrator on overflow instead of wrapping.
module id_terms
  import pid_pkg::*;
#(
  parameter logic [4:0] D_COEFF    = 5'd7,
  parameter int         HIST_DEPTH = 2,
  parameter int         I_SHIFT    = 4
) (
  input  logic       clk,
  input  logic       rst,
  id_terms_if.slave  bus
);

  localparam int DIFF_W = ERR_W + 1;

  pid_state_e              state_q, state_d;
  logic signed [INTEG_W-1:0] integ_q, integ_d;
  logic signed [I_W-1:0]   i_term_q, i_term_d;
  logic signed [D_W-1:0]   d_term_q, d_term_d;
  logic                    vld_q, vld_d;

  logic                    accept_s;
  logic signed [ERR_W-1:0] oldest_s;
  logic                    hist_full_s;
  logic                    hist_last_s;
  logic signed [INTEG_W-1:0] sum_s;
  logic signed [INTEG_W-1:0] integ_nxt_s;
  logic signed [DIFF_W-1:0] diff_s;
  logic signed [7:0]       sat8_s;
  logic signed [5:0]       dcoef_s;
  logic signed [D_W-1:0]   d_prod_s;

  assign accept_s = bus.hdng_vld && bus.moving;

  err_hist #(.DEPTH(HIST_DEPTH), .W(ERR_W)) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (!bus.moving),
    .shift_i  (accept_s),
    .din_i    (bus.err_sat),
    .oldest_o (oldest_s),
    .full_o   (hist_full_s),
    .last_o   (hist_last_s)
  );

  assign sum_s = integ_q + INTEG_W'(bus.err_sat);

`ifdef ID_TERM_ANTIWINDUP_EN
  logic ovf_s;
  assign ovf_s = (integ_q[INTEG_W-1] == bus.err_sat[ERR_W-1]) &&
                 (sum_s[INTEG_W-1] != integ_q[INTEG_W-1]);
  assign integ_nxt_s = ovf_s ? integ_q : sum_s;
`else
  assign integ_nxt_s = sum_s;
`endif

  // Derivative: 12-bit difference against the sample HIST_DEPTH back, clipped to 8 bits.
  assign diff_s   = DIFF_W'(bus.err_sat) - DIFF_W'(oldest_s);
  assign sat8_s   = 8'(sat_signed(32'(diff_s), 32'd8));
  assign dcoef_s  = $signed({1'b0, D_COEFF});
  assign d_prod_s = D_W'(sat8_s) * D_W'(dcoef_s);

  always_comb begin
    state_d = state_q;
    if (!bus.moving) begin
      state_d = IDLE;
    end else if (accept_s) begin
      state_d = (hist_full_s || hist_last_s) ? RUN : FILL;
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    integ_d  = integ_q;
    i_term_d = i_term_q;
    d_term_d = d_term_q;
    vld_d    = 1'b0;
    if (!bus.moving) begin
      integ_d  = '0;
      i_term_d = '0;
      d_term_d = '0;
    end else if (accept_s) begin
      integ_d  = integ_nxt_s;
      i_term_d = I_W'(integ_nxt_s >>> I_SHIFT);
      // Until the history holds HIST_DEPTH samples there is nothing valid to difference against.
      d_term_d = (state_q == RUN) ? d_prod_s : '0;
      vld_d    = 1'b1;
    end else begin
      vld_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      integ_q  <= '0;
      i_term_q <= '0;
      d_term_q <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      integ_q  <= integ_d;
      i_term_q <= i_term_d;
      d_term_q <= d_term_d;
      vld_q    <= vld_d;
    end
  end

  assign bus.I_term    = i_term_q;
  assign bus.D_term    = d_term_q;
  assign bus.terms_vld = vld_q;

endmodule

// File: tb/tb_id_terms.sv
// Self-checking bench for id_terms: behavioural model feeds an expected-result queue
// that the output monitor drains on every terms_vld pulse.
module tb_id_terms;

  localparam int DEPTH = 2;
  localparam int COEFF = 7;

  typedef struct {
    int i;
    int d;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   pulses;
  exp_t exp_q[$];
  exp_t mon_e;
  int   m_integ;
  int   m_hist[$];

  id_terms_if bus ();

  id_terms #(.D_COEFF(5'd7), .HIST_DEPTH(DEPTH), .I_SHIFT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function void model_clear();
    m_integ = 0;
    m_hist.delete();
  endfunction

  function void model_accept(input int v);
    int   sum;
    int   d;
    exp_t e;
    sum = m_integ + v;
    if (sum > 32767 || sum < -32768) begin
`ifdef ID_TERM_ANTIWINDUP_EN
      sum = m_integ;
`else
      sum = (sum > 32767) ? sum - 65536 : sum + 65536;
`endif
    end
    m_integ = sum;
    if (m_hist.size() >= DEPTH) begin
      d = v - m_hist[DEPTH-1];
      if (d > 127) d = 127;
      if (d < -128) d = -128;
      d = d * COEFF;
    end else begin
      d = 0;
    end
    m_hist.push_front(v);
    if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
    e.i = m_integ >>> 4;
    e.d = d;
    exp_q.push_back(e);
  endfunction

  // Output monitor: every pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #2;
    if (bus.terms_vld === 1'b1) begin
      pulses++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_vld: terms_vld=1 with no sample outstanding at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (int'(bus.I_term) !== mon_e.i || int'(bus.D_term) !== mon_e.d) begin
          failures++;
          $display("FAIL terms: got I=%0d D=%0d, expected I=%0d D=%0d at %0t",
                   int'(bus.I_term), int'(bus.D_term), mon_e.i, mon_e.d, $time);
        end
      end
    end
  end

  task automatic send(input int v);
    @(negedge clk);
    bus.hdng_vld = 1'b1;
    bus.err_sat  = 11'(v);
    model_accept(v);
    @(negedge clk);
    bus.hdng_vld = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL latency: %0d results outstanding one cycle after strobe", exp_q.size());
    end
  endtask

  task automatic restart();
    @(negedge clk);
    bus.moving = 1'b0;
    model_clear();
    @(negedge clk);
    bus.moving = 1'b1;
  endtask

  task automatic test_reset();
    int p0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.terms_vld !== 1'b0 || bus.I_term !== 12'sd0 || bus.D_term !== 13'sd0) begin
      failures++;
      $display("FAIL reset_state: vld=%0b I=%0d D=%0d, expected all 0",
               bus.terms_vld, bus.I_term, bus.D_term);
    end
    rst = 1'b0;
    @(negedge clk);
    bus.moving = 1'b1;
    send(100);
    send(200);
    p0 = pulses;
    // Assert reset between edges while a sample is pending.
    @(negedge clk);
    bus.hdng_vld = 1'b1;
    bus.err_sat  = 11'sd300;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.terms_vld !== 1'b0 || bus.I_term !== 12'sd0 || bus.D_term !== 13'sd0) begin
      failures++;
      $display("FAIL reset_async: vld=%0b I=%0d D=%0d, expected all 0",
               bus.terms_vld, bus.I_term, bus.D_term);
    end
    model_clear();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.hdng_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (pulses !== p0) begin
      failures++;
      $display("FAIL reset_discard: pulses=%0d, expected %0d", pulses, p0);
    end
  endtask

  task automatic test_ramp();
    int p0;
    restart();
    p0 = pulses;
    send(16);
    send(48);
    send(80);
    checks++;
    if (bus.I_term !== 12'sd9 || bus.D_term !== 13'sd448) begin
      failures++;
      $display("FAIL ramp_final: I=%0d D=%0d, expected I=9 D=448", bus.I_term, bus.D_term);
    end
    @(negedge clk);
    checks++;
    if (bus.terms_vld !== 1'b0 || pulses !== p0 + 3 || bus.I_term !== 12'sd9) begin
      failures++;
      $display("FAIL ramp_hold: vld=%0b pulses=%0d I=%0d, expected vld=0 pulses=%0d I=9",
               bus.terms_vld, pulses - p0, bus.I_term, 3);
    end
  endtask

  task automatic test_windup();
    restart();
    for (int n = 0; n < 32; n++) send(1023);
    checks++;
    if (bus.I_term !== 12'sd2046) begin
      failures++;
      $display("FAIL windup_32: I=%0d, expected 2046", bus.I_term);
    end
    send(1023);
    checks++;
`ifdef ID_TERM_ANTIWINDUP_EN
    if (bus.I_term !== 12'sd2046) begin
      failures++;
      $display("FAIL windup_33: I=%0d, expected 2046", bus.I_term);
    end
`else
    if (bus.I_term !== -12'sd1987) begin
      failures++;
      $display("FAIL windup_33: I=%0d, expected -1987", bus.I_term);
    end
`endif
  endtask

  task automatic test_dsat();
    restart();
    send(-1024);
    send(0);
    send(1023);
    checks++;
    if (bus.D_term !== 13'sd889) begin
      failures++;
      $display("FAIL dsat_pos: D=%0d, expected 889", bus.D_term);
    end
    restart();
    send(1023);
    send(0);
    send(-1024);
    checks++;
    if (bus.D_term !== -13'sd896) begin
      failures++;
      $display("FAIL dsat_neg: D=%0d, expected -896", bus.D_term);
    end
  endtask

  task automatic test_motion_drop();
    int p0;
    restart();
    send(30);
    send(60);
    send(90);
    p0 = pulses;
    @(negedge clk);
    bus.moving   = 1'b0;
    bus.hdng_vld = 1'b1;
    bus.err_sat  = 11'sd500;
    model_clear();
    @(negedge clk);
    bus.hdng_vld = 1'b0;
    checks++;
    if (bus.terms_vld !== 1'b0 || bus.I_term !== 12'sd0 || bus.D_term !== 13'sd0 || pulses !== p0) begin
      failures++;
      $display("FAIL drop_clear: vld=%0b I=%0d D=%0d pulses=%0d, expected 0 0 0 %0d",
               bus.terms_vld, bus.I_term, bus.D_term, pulses, p0);
    end
    bus.moving = 1'b1;
    send(200);
    checks++;
    if (bus.D_term !== 13'sd0) begin
      failures++;
      $display("FAIL drop_refill1: D=%0d, expected 0", bus.D_term);
    end
    send(-300);
    checks++;
    if (bus.D_term !== 13'sd0) begin
      failures++;
      $display("FAIL drop_refill2: D=%0d, expected 0", bus.D_term);
    end
    send(100);
  endtask

  task automatic test_ignored();
    int p0;
    p0 = pulses;
    @(negedge clk);
    bus.moving = 1'b0;
    model_clear();
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      bus.hdng_vld = 1'b1;
      bus.err_sat  = 11'sd400;
    end
    @(negedge clk);
    bus.hdng_vld = 1'b0;
    checks++;
    if (pulses !== p0 || bus.I_term !== 12'sd0 || bus.D_term !== 13'sd0) begin
      failures++;
      $display("FAIL ignored: pulses=%0d I=%0d D=%0d, expected %0d 0 0",
               pulses, bus.I_term, bus.D_term, p0);
    end
    bus.moving = 1'b1;
    send(50);
    checks++;
    if (bus.D_term !== 13'sd0) begin
      failures++;
      $display("FAIL ignored_idle: D=%0d after first sample, expected 0", bus.D_term);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    int vals[5];
    vals = '{10, -40, 250, -600, 7};
    restart();
    p0 = pulses;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      bus.hdng_vld = 1'b1;
      bus.err_sat  = 11'(vals[n]);
      model_accept(vals[n]);
    end
    @(negedge clk);
    bus.hdng_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (pulses !== p0 + 5 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL back_to_back: pulses=%0d outstanding=%0d, expected 5 and 0",
               pulses - p0, exp_q.size());
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    pulses       = 0;
    rst          = 1'b1;
    bus.moving   = 1'b0;
    bus.hdng_vld = 1'b0;
    bus.err_sat  = '0;
    model_clear();
    test_reset();
    test_ramp();
    test_windup();
    test_dsat();
    test_motion_drop();
    test_ignored();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_terms.md
# id_terms

Integral and derivative term generator for the heading PID loop. Consumes the 11-bit saturated heading error produced by the proportional stage, once per valid heading sample. Maintains a 16-bit integrator and a short error history, and produces registered, saturated `I_term` and `D_term` with a one-cycle valid strobe. The PID summer downstream adds these to `P_term`.

## Interface
- `D_COEFF`, default 5'd7: unsigned derivative gain.
- `HIST_DEPTH`, default 2: number of valid samples back used for the derivative difference; legal range 1–4.
- `I_SHIFT`, default 4: integrator-to-`I_term` right shift; fixed by the 12-bit output width.
- `clk` input 1: system clock.
- `rst` input 1: reset; asynchronous, active-high.
- `moving` input 1: robot in motion; low clears all state.
- `hdng_vld` input 1: one-cycle strobe marking a new `err_sat`.
- `err_sat` input 11, signed: saturated heading error.
- `I_term` output 12, signed: integral term.
- `D_term` output 13, signed: derivative term.
- `terms_vld` output 1: one-cycle pulse when `I_term`/`D_term` update.

## Operation
- A sample is accepted on a rising clock edge when `hdng_vld && moving`. It is ignored when `moving=0`.
- State machine:
  - IDLE: `moving=0`.
  - FILL: accepted samples < `HIST_DEPTH`.
  - RUN: history full.
  - Transitions: IDLE→FILL on the first accepted sample. FILL→RUN when `HIST_DEPTH` samples are held. Any state→IDLE when `moving=0`.
- In IDLE, the integrator, history, fill count and all outputs are cleared.
- Integrator, 16-bit signed:
  - On an accepted sample, `sum = integ + sext16(err_sat)`.
  - Overflow is defined as equal operand signs with a differing `sum` sign. The overflow behaviour depends on `ID_TERM_ANTIWINDUP_EN` (see Configuration).
  - `I_term = integ_next >>> I_SHIFT`, an arithmetic shift of the post-update value.
- Derivative:
  - `diff = err_sat - hist[HIST_DEPTH-1]`, computed at 12 bits signed.
  - `diff` saturates to 8-bit signed [-128, 127].
  - `D_term = sat8 * D_COEFF`, signed result, 13 bits.
  - In FILL, `D_term` updates to 0.
  - The history shifts on every accepted sample.
- If `moving` and `hdng_vld` are both high in the cycle that leaves IDLE, the sample is accepted normally.

## Timing
- Latency: one cycle from an accepted `hdng_vld` to updated outputs, with `terms_vld` high for exactly that cycle.
- Outputs hold their values between samples.
- `moving` falling: the next edge zeroes `I_term`, `D_term` and `terms_vld`, and the state goes to IDLE. An `hdng_vld` in that same cycle is dropped.
- `rst` asserts asynchronously: state=IDLE and `I_term`, `D_term`, `terms_vld`, integrator and history are all 0. Deassertion takes effect at the next edge. Reset mid-sample discards the sample.
- Back-to-back `hdng_vld` on consecutive cycles is legal. Each strobe produces its own `terms_vld` pulse.

## Configuration
- `ID_TERM_ANTIWINDUP_EN` defined: on overflow the integrator holds its prior value. `I_term` still updates from the held value and `terms_vld` still pulses.
- `ID_TERM_ANTIWINDUP_EN` undefined: the integrator wraps two's-complement. This is cheaper and intended only for gain-tuning experiments.

## Structure
- `pid_pkg` holds:
  - width constants: `ERR_W=11`, `INTEG_W=16`, `I_W=12`, `D_W=13`;
  - the state enum: IDLE, FILL, RUN;
  - a `sat_signed` function shared with the P and summing stages.
- Sub-module `err_hist`: a parameterized `HIST_DEPTH`-deep shift register of `err_sat` with shift enable, clear, and a `full` flag. The top level holds the FSM, integrator, derivative arithmetic and output registers.

## Test plan
- Reset: assert `rst` mid-run → `I_term=0`, `D_term=0`, `terms_vld=0` immediately; state IDLE.
- Ramp: `moving=1`, samples 16, 48, 80 →
  - `I_term` = 1, 4, 9;
  - `D_term` = 0, 0, 448 ((80-16)*7);
  - one `terms_vld` pulse each, one cycle after the strobe.
- Windup: 33 samples of 1023 →
  - after 32 samples, integrator=32736, `I_term=2046`;
  - 33rd sample with the macro: integrator holds 32736, `I_term=2046`;
  - 33rd sample without the macro: integrator wraps to -31777, `I_term=-1987`.
- D saturation, samples -1024, x, 1023 → `D_term=889` (diff 2047 clipped to 127). Samples 1023, x, -1024 → `D_term=-896`.
- Motion drop: `moving` falls in RUN → outputs 0 the next cycle. After re-raising `moving`, the first two samples give `D_term=0`.
- Ignored strobe: `hdng_vld` with `moving=0` → no `terms_vld`, outputs stay 0, state stays IDLE.
